// File: rtl/shift_register_engine.sv
// Parametrised clear/load register with a multi-cycle shift/rotate engine.
// One bit moves per clock; completion is reported with a busy/done handshake.
module shift_register_engine #(
  parameter int                 WIDTH       = 8,
  parameter logic [WIDTH-1:0]   RESET_VALUE = '0,
  localparam int                SHW         = $clog2(WIDTH + 1)
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             in_clear,
  input  logic             in_load,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_start,
  input  logic [1:0]       in_mode,
  input  logic [SHW-1:0]   in_shamt,
  input  logic             in_serial,
  output logic [WIDTH-1:0] out_data,
  output logic             out_busy,
  output logic             out_done,
  output logic             out_serial,
  output logic             dbg_state
);

  // Handshake: in_start is accepted only on an edge where the engine is IDLE
  // and in_load is low. out_done pulses for exactly one cycle when the
  // operation's last step has landed. out_busy is high while more than the
  // final step is still outstanding. A new in_start may be issued in the
  // out_done cycle. in_clear aborts an operation and no out_done follows.

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  localparam logic [1:0]     MODE_SHL = 2'b00;
  localparam logic [1:0]     MODE_SHR = 2'b01;
  localparam logic [1:0]     MODE_ROL = 2'b10;
  localparam logic [1:0]     MODE_ROR = 2'b11;
  localparam logic [SHW-1:0] CNT_ONE  = SHW'(1);
  localparam logic [SHW-1:0] CNT_TWO  = SHW'(2);

  state_t           state;
  logic [1:0]       mode_q;
  logic [SHW-1:0]   cnt_q;
  logic [WIDTH-1:0] step_data;
  logic             step_bit;

  // Next register value and ejected bit for a single step in the latched mode.
  always_comb begin
    step_data = out_data;
    step_bit  = 1'b0;
    case (mode_q)
      MODE_SHL: begin
        step_data = {out_data[WIDTH-2:0], in_serial};
        step_bit  = out_data[WIDTH-1];
      end
      MODE_SHR: begin
        step_data = {in_serial, out_data[WIDTH-1:1]};
        step_bit  = out_data[0];
      end
      MODE_ROL: begin
        step_data = {out_data[WIDTH-2:0], out_data[WIDTH-1]};
        step_bit  = out_data[WIDTH-1];
      end
      MODE_ROR: begin
        step_data = {out_data[0], out_data[WIDTH-1:1]};
        step_bit  = out_data[0];
      end
      default: begin
        step_data = out_data;
        step_bit  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state      <= IDLE;
      mode_q     <= MODE_SHL;
      cnt_q      <= '0;
      out_data   <= RESET_VALUE;
      out_busy   <= 1'b0;
      out_done   <= 1'b0;
      out_serial <= 1'b0;
    end else begin
      out_done <= 1'b0;
      if (in_clear) begin
        state    <= IDLE;
        cnt_q    <= '0;
        out_data <= RESET_VALUE;
        out_busy <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (in_load) begin
              out_data <= in_data;
            end else if (in_start) begin
              if (in_shamt == '0) begin
                out_done <= 1'b1;
              end else begin
                mode_q   <= in_mode;
                cnt_q    <= in_shamt;
                state    <= SHIFT;
                out_busy <= (in_shamt > CNT_ONE);
              end
            end
          end
          SHIFT: begin
            out_data   <= step_data;
            out_serial <= step_bit;
            cnt_q      <= cnt_q - CNT_ONE;
            // Busy tracks the steps still pending after this one, excluding the last.
            if (cnt_q == CNT_ONE) begin
              state    <= IDLE;
              out_busy <= 1'b0;
              out_done <= 1'b1;
            end else begin
              out_busy <= (cnt_q > CNT_TWO);
            end
          end
          default: begin
            state    <= IDLE;
            out_busy <= 1'b0;
          end
        endcase
      end
    end
  end

  assign dbg_state = state;

endmodule

// File: tb/tb_shift_register_engine.sv
// Directed bench for shift_register_engine: an 8-bit instance for function and
// protection, a 16-bit instance with a non-zero reset value for the sweep.
module tb_shift_register_engine;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // 8-bit instance
  logic       a_rst = 1'b1, a_clear = 1'b0, a_load = 1'b0, a_start = 1'b0, a_serial = 1'b0;
  logic [7:0] a_data_in = '0;
  logic [1:0] a_mode = '0;
  logic [3:0] a_shamt = '0;
  logic [7:0] a_data;
  logic       a_busy, a_done, a_sout, a_state;

  // 16-bit instance
  logic        b_rst = 1'b1, b_clear = 1'b0, b_load = 1'b0, b_start = 1'b0, b_serial = 1'b0;
  logic [15:0] b_data_in = '0;
  logic [1:0]  b_mode = '0;
  logic [4:0]  b_shamt = '0;
  logic [15:0] b_data;
  logic        b_busy, b_done, b_sout, b_state;

  shift_register_engine #(.WIDTH(8)) u_dut8 (
    .clk_in(clk), .rst_in(a_rst), .in_clear(a_clear), .in_load(a_load),
    .in_data(a_data_in), .in_start(a_start), .in_mode(a_mode), .in_shamt(a_shamt),
    .in_serial(a_serial), .out_data(a_data), .out_busy(a_busy), .out_done(a_done),
    .out_serial(a_sout), .dbg_state(a_state)
  );

  shift_register_engine #(.WIDTH(16), .RESET_VALUE(16'hBEEF)) u_dut16 (
    .clk_in(clk), .rst_in(b_rst), .in_clear(b_clear), .in_load(b_load),
    .in_data(b_data_in), .in_start(b_start), .in_mode(b_mode), .in_shamt(b_shamt),
    .in_serial(b_serial), .out_data(b_data), .out_busy(b_busy), .out_done(b_done),
    .out_serial(b_sout), .dbg_state(b_state)
  );

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic sb_check(input string tag, input logic [31:0] obs);
    logic [31:0] exp;
    check({tag, "_sb_depth"}, exp_q.size(), 1);
    if (exp_q.size() > 0) begin
      exp = exp_q.pop_front();
      check({tag, "_data"}, obs, exp);
    end
  endtask

  // Reference behaviour of N single-bit steps; ser[k] is the fill bit of step k.
  function automatic logic [7:0] model8(input logic [7:0] d, input logic [1:0] m,
                                        input int n, input logic [63:0] ser);
    logic [7:0] r;
    r = d;
    for (int k = 0; k < n; k++) begin
      case (m)
        2'b00: r = {r[6:0], ser[k]};
        2'b01: r = {ser[k], r[7:1]};
        2'b10: r = {r[6:0], r[7]};
        default: r = {r[0], r[7:1]};
      endcase
    end
    return r;
  endfunction

  task automatic load8(input logic [7:0] v);
    a_data_in = v;
    a_load = 1'b1;
    tick();
    a_load = 1'b0;
  endtask

  // Starts an operation, streams serial bits, and checks latency, busy length
  // and the final data against the scoreboard. Returns in the done cycle.
  task automatic do_op(input string tag, input logic [1:0] mode, input int n,
                       input logic [63:0] ser, input bit perturb);
    int cyc;
    int busy_cnt;
    a_mode = mode;
    a_shamt = n[3:0];
    a_start = 1'b1;
    tick();
    a_start = 1'b0;
    cyc = 0;
    busy_cnt = 0;
    while (!a_done && cyc < 40) begin
      a_serial = ser[cyc];
      if (perturb && cyc == 1) begin
        a_load = 1'b1;
        a_start = 1'b1;
        a_mode = ~mode;
        a_shamt = 4'd2;
        a_data_in = 8'hFF;
      end else begin
        a_load = 1'b0;
        a_start = 1'b0;
        a_mode = mode;
      end
      if (a_busy) busy_cnt++;
      tick();
      cyc++;
    end
    a_load = 1'b0;
    a_start = 1'b0;
    check({tag, "_done_seen"}, a_done, 1);
    check({tag, "_latency"}, cyc, n);
    check({tag, "_busy_cycles"}, busy_cnt, (n > 1) ? n - 1 : 0);
    check({tag, "_busy_in_done"}, a_busy, 0);
    sb_check(tag, a_data);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0]  rd;
    logic [1:0]  rm;
    int          rn;
    int          dones;
    int          busy_cnt;
    int          cyc;
    logic [63:0] rs;
    logic        prev_sout;

    // ---- 8-bit: reset and clear
    tick();
    tick();
    check("rst_data", a_data, 8'h00);
    check("rst_busy", a_busy, 0);
    check("rst_done", a_done, 0);
    check("rst_serial", a_sout, 0);
    check("rst_state", a_state, 0);
    a_rst = 1'b0;
    tick();
    load8(8'hA5);
    check("load_a5", a_data, 8'hA5);
    a_clear = 1'b1;
    tick();
    a_clear = 1'b0;
    check("clear_data", a_data, 8'h00);

    // ---- SHL with serial fill 1,0,1
    load8(8'h81);
    exp_q.push_back(32'h0D);
    do_op("shl3", 2'b00, 3, 64'b101, 1'b0);
    check("shl3_serial", a_sout, 0);
    tick();
    check("shl3_done_once", a_done, 0);

    // ---- ROR 4 then back-to-back ROL 12
    load8(8'h96);
    exp_q.push_back(32'h69);
    do_op("ror4", 2'b11, 4, 64'd0, 1'b0);
    exp_q.push_back(32'h96);
    do_op("rol12", 2'b10, 12, 64'd0, 1'b0);
    tick();
    check("rol12_done_once", a_done, 0);

    // ---- N=0: done next cycle, data and serial unchanged
    prev_sout = a_sout;
    exp_q.push_back(32'h96);
    do_op("n0", 2'b00, 0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
    check("n0_serial", a_sout, prev_sout);
    tick();
    check("n0_done_once", a_done, 0);

    // ---- load and start on the same edge
    a_data_in = 8'h3C;
    a_load = 1'b1;
    a_start = 1'b1;
    a_shamt = 4'd2;
    a_mode = 2'b00;
    tick();
    a_load = 1'b0;
    a_start = 1'b0;
    check("ldst_data", a_data, 8'h3C);
    check("ldst_state", a_state, 0);
    dones = 0;
    busy_cnt = 0;
    for (int i = 0; i < 4; i++) begin
      if (a_done) dones++;
      if (a_busy) busy_cnt++;
      tick();
    end
    check("ldst_no_done", dones, 0);
    check("ldst_no_busy", busy_cnt, 0);
    check("ldst_data_hold", a_data, 8'h3C);

    // ---- SHR 5 with load/start/mode noise mid-operation
    load8(8'h5A);
    rs = 64'($urandom_range(0, 31));
    exp_q.push_back(32'(model8(8'h5A, 2'b01, 5, rs)));
    do_op("shr5_prot", 2'b01, 5, rs, 1'b1);

    // ---- clear at step 2 aborts without done
    load8(8'hC3);
    a_mode = 2'b01;
    a_shamt = 4'd5;
    a_start = 1'b1;
    tick();
    a_start = 1'b0;
    a_serial = 1'b1;
    tick();
    check("abort_step1", a_data, 8'hE1);
    a_clear = 1'b1;
    tick();
    a_clear = 1'b0;
    check("abort_data", a_data, 8'h00);
    check("abort_busy", a_busy, 0);
    check("abort_state", a_state, 0);
    dones = 0;
    for (int i = 0; i < 8; i++) begin
      if (a_done) dones++;
      tick();
    end
    check("abort_no_done", dones, 0);

    // ---- random operations against the reference model
    for (int i = 0; i < 4; i++) begin
      rd = 8'($urandom_range(0, 255));
      rm = 2'($urandom_range(0, 3));
      rn = $urandom_range(1, 10);
      rs = {$urandom, $urandom};
      load8(rd);
      exp_q.push_back(32'(model8(rd, rm, rn, rs)));
      do_op($sformatf("rand%0d", i), rm, rn, rs, 1'b0);
    end

    // ---- asynchronous reset mid-shift
    load8(8'hFF);
    a_mode = 2'b10;
    a_shamt = 4'd6;
    a_start = 1'b1;
    tick();
    a_start = 1'b0;
    tick();
    #2;
    a_rst = 1'b1;
    #1;
    check("arst_data", a_data, 8'h00);
    check("arst_busy", a_busy, 0);
    check("arst_state", a_state, 0);
    check("arst_serial", a_sout, 0);
    @(posedge clk);
    #1;
    a_rst = 1'b0;
    dones = 0;
    for (int i = 0; i < 8; i++) begin
      if (a_done) dones++;
      tick();
    end
    check("arst_no_done", dones, 0);

    // ---- 16-bit instance with RESET_VALUE 0xBEEF
    check("w16_rst_data", b_data, 16'hBEEF);
    check("w16_rst_busy", b_busy, 0);
    b_rst = 1'b0;
    tick();
    b_data_in = 16'h1234;
    b_load = 1'b1;
    tick();
    b_load = 1'b0;
    check("w16_load", b_data, 16'h1234);
    b_clear = 1'b1;
    tick();
    b_clear = 1'b0;
    check("w16_clear", b_data, 16'hBEEF);
    b_data_in = 16'hABCD;
    b_load = 1'b1;
    tick();
    b_load = 1'b0;
    b_mode = 2'b01;
    b_shamt = 5'd16;
    b_serial = 1'b0;
    exp_q.push_back(32'h0000);
    b_start = 1'b1;
    tick();
    b_start = 1'b0;
    cyc = 0;
    busy_cnt = 0;
    while (!b_done && cyc < 40) begin
      if (b_busy) busy_cnt++;
      tick();
      cyc++;
    end
    check("w16_done_seen", b_done, 1);
    check("w16_latency", cyc, 16);
    check("w16_busy_cycles", busy_cnt, 15);
    sb_check("w16_shr16", b_data);
    tick();
    check("w16_done_once", b_done, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
